alu_mp_seq: RTL and testbench

//  Multi-precision sequencer that sits directly upstream of the 8-bit ALU.
//  It runs a multi-byte ADD, SUB, SHL or SHR by streaming operand bytes from data memory into the ALU.
//  It chains the ALU shift/carry signal (sc_o to sc_i) between bytes and writes each result byte back to memory.
//  The processor control starts an operation and stalls on busy until the done pulse.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_mp_seq.sv | 185 ++++++++++++++++++
 tb/tb_alu_mp_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and the multi-precision sequencer:
// ALU command encodings, the multi-precision op enum and the sequencer states.
package alu_pkg;

    // ALU command encodings
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SHL  = 3'b001;
    localparam logic [2:0] ALU_SHR  = 3'b010;
    localparam logic [2:0] ALU_NAND = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;

    // Multi-precision operations handled by the sequencer
    typedef enum logic [1:0] {
        MP_ADD = 2'd0,
        MP_SUB = 2'd1,
        MP_SHL = 2'd2,
        MP_SHR = 2'd3
    } mp_op_t;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        DONE = 3'd4
    } seq_state_t;

    // Shifts only need operand A, so they skip the RD_B cycle
    function automatic logic is_shift(input mp_op_t op);
        return (op == MP_SHL) || (op == MP_SHR);
    endfunction

    // Value fed into alu_sc_i for the first byte processed.
    // SUB is done as A + ~B + 1, so its chain starts with a carry of 1.
    function automatic logic first_sc(input mp_op_t op, input logic fill);
        logic sc;
        case (op)
            MP_ADD:  sc = 1'b0;
            MP_SUB:  sc = 1'b1;
            default: sc = fill;
        endcase
        return sc;
    endfunction

endpackage

// File: rtl/alu_mp_seq.sv
// Multi-precision sequencer: streams operand bytes from a sync-read data
// memory through an external 8-bit ALU, chaining the ALU shift/carry signal
// between bytes and writing each result byte back to memory.
module alu_mp_seq
    import alu_pkg::*;
#(
    parameter int AW     = 8,
    parameter int MAXLEN = 16,
    localparam int LW    = $clog2(MAXLEN + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  mp_op_t        op,
    input  logic [LW-1:0] len,
    input  logic [AW-1:0] a_base,
    input  logic [AW-1:0] b_base,
    input  logic [AW-1:0] r_base,
    input  logic          fill_i,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [7:0]    mem_wdata,
    output logic [2:0]    alu_cmd,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic          alu_sc_i,
    input  logic [7:0]    alu_rslt,
    input  logic          alu_sc_o,
    output logic          busy,
    output logic          done,
    output logic          carry_o,
    output logic          zero_o
);

    localparam logic [LW-1:0] MAXLEN_L = LW'(MAXLEN);
    localparam logic [LW-1:0] ONE_L    = LW'(1);

    seq_state_t    state_reg, state_next;
    mp_op_t        op_reg;
    logic [AW-1:0] a_base_reg, b_base_reg, r_base_reg;
    logic [LW-1:0] idx_reg;     // byte currently being processed
    logic [LW-1:0] cnt_reg;     // bytes still to execute, including the current one
    logic [7:0]    a_q_reg;     // operand A byte held while B is read
    logic          carry_reg;   // shift/carry chain between bytes
    logic          zero_reg;    // AND of (result byte == 0) so far

    logic [LW-1:0] len_clamped;
    logic [AW-1:0] idx_ext;

    assign len_clamped = (len > MAXLEN_L) ? MAXLEN_L : len;
    assign idx_ext     = AW'(idx_reg);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (len_clamped == '0) ? DONE : RD_A;
                end
            end
            RD_A:    state_next = is_shift(op_reg) ? EXEC : RD_B;
            RD_B:    state_next = EXEC;
            EXEC:    state_next = (cnt_reg == ONE_L) ? DONE : RD_A;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operation context, byte index/count, operand capture, carry chain and zero flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_reg     <= MP_ADD;
            a_base_reg <= '0;
            b_base_reg <= '0;
            r_base_reg <= '0;
            idx_reg    <= '0;
            cnt_reg    <= '0;
            a_q_reg    <= '0;
            carry_reg  <= 1'b0;
            zero_reg   <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_reg     <= op;
                        a_base_reg <= a_base;
                        b_base_reg <= b_base;
                        r_base_reg <= r_base;
                        cnt_reg    <= len_clamped;
                        // SHR walks from the most significant byte downwards
                        if (op == MP_SHR && len_clamped != '0) begin
                            idx_reg <= len_clamped - ONE_L;
                        end else begin
                            idx_reg <= '0;
                        end
                        // Seeding the chain with the first-byte sc_i also gives the
                        // len==0 carry_o value for free
                        carry_reg  <= first_sc(op, fill_i);
                        zero_reg   <= 1'b1;
                    end
                end
                RD_B: begin
                    a_q_reg <= mem_rdata;
                end
                EXEC: begin
                    carry_reg <= alu_sc_o;
                    zero_reg  <= zero_reg & (alu_rslt == 8'h00);
                    cnt_reg   <= cnt_reg - ONE_L;
                    if (op_reg == MP_SHR) begin
                        idx_reg <= idx_reg - ONE_L;
                    end else begin
                        idx_reg <= idx_reg + ONE_L;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Memory and ALU drive decoded from the current state
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_waddr = '0;
        alu_cmd   = ALU_ADD;
        alu_a     = 8'h00;
        alu_b     = 8'h00;
        alu_sc_i  = 1'b0;
        case (state_reg)
            RD_A: mem_addr = a_base_reg + idx_ext;
            RD_B: mem_addr = b_base_reg + idx_ext;
            EXEC: begin
                mem_we    = 1'b1;
                mem_waddr = r_base_reg + idx_ext;
                alu_sc_i  = carry_reg;
                // Subtraction uses ALU_ADD on ~B so the carry chains like an add;
                // shifts read A straight off the memory port (no RD_B cycle)
                case (op_reg)
                    MP_ADD: begin
                        alu_cmd = ALU_ADD;
                        alu_a   = a_q_reg;
                        alu_b   = mem_rdata;
                    end
                    MP_SUB: begin
                        alu_cmd = ALU_ADD;
                        alu_a   = a_q_reg;
                        alu_b   = ~mem_rdata;
                    end
                    MP_SHL: begin
                        alu_cmd = ALU_SHL;
                        alu_a   = mem_rdata;
                    end
                    MP_SHR: begin
                        alu_cmd = ALU_SHR;
                        alu_a   = mem_rdata;
                    end
                    default: begin
                    end
                endcase
            end
            default: begin
            end
        endcase
    end

    assign mem_wdata = alu_rslt;
    assign busy      = (state_reg == RD_A) || (state_reg == RD_B) || (state_reg == EXEC);
    assign done      = (state_reg == DONE);
    assign carry_o   = carry_reg;
    assign zero_o    = zero_reg;

endmodule

// File: tb/tb_alu_mp_seq.sv
// Bench for alu_mp_seq: behavioural 8-bit ALU, 256x8 sync-read memory and a
// write scoreboard; one line printed per operation.
module tb_alu_mp_seq;
    import alu_pkg::*;

    localparam int AW     = 8;
    localparam int MAXLEN = 16;
    localparam int LW     = $clog2(MAXLEN + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    mp_op_t        op = MP_ADD;
    logic [LW-1:0] len = '0;
    logic [AW-1:0] a_base = '0, b_base = '0, r_base = '0;
    logic          fill_i = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic [2:0]    alu_cmd;
    logic [7:0]    alu_a, alu_b;
    logic          alu_sc_i;
    logic [7:0]    alu_rslt;
    logic          alu_sc_o;
    logic          busy, done, carry_o, zero_o;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    alu_mp_seq #(.AW(AW), .MAXLEN(MAXLEN)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .len(len),
        .a_base(a_base), .b_base(b_base), .r_base(r_base), .fill_i(fill_i),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .alu_cmd(alu_cmd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sc_i(alu_sc_i), .alu_rslt(alu_rslt),
        .alu_sc_o(alu_sc_o), .busy(busy), .done(done), .carry_o(carry_o), .zero_o(zero_o)
    );

    // Behavioural 8-bit ALU
    always_comb begin
        alu_rslt = 8'h00;
        alu_sc_o = 1'b0;
        case (alu_cmd)
            ALU_ADD:  {alu_sc_o, alu_rslt} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_sc_i};
            ALU_SHL:  begin alu_rslt = {alu_a[6:0], alu_sc_i}; alu_sc_o = alu_a[7]; end
            ALU_SHR:  begin alu_rslt = {alu_sc_i, alu_a[7:1]}; alu_sc_o = alu_a[0]; end
            ALU_NAND: alu_rslt = ~(alu_a & alu_b);
            default:  {alu_sc_o, alu_rslt} = {1'b0, alu_a} - {1'b0, alu_b};
        endcase
    end

    // 256x8 sync-read memory; the bench preloads through its own write port
    logic [7:0] mem [0:255];
    logic       tb_we = 1'b0;
    logic [7:0] tb_waddr = '0, tb_wdata = '0;
    always @(posedge clk) begin
        if (tb_we) mem[tb_waddr] <= tb_wdata;
        else if (mem_we) mem[mem_waddr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] base, input int n, input logic [127:0] val);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tb_we = 1'b1; tb_waddr = base + 8'(i); tb_wdata = val[i*8 +: 8];
            @(posedge clk); #1;
            tb_we = 1'b0;
        end
    endtask

    // Launch one op, score its writes and check latency/flags. poke pulses
    // start (with different inputs) mid-operation and again during DONE.
    task automatic run_op(input string tag, input mp_op_t o, input int n,
                          input logic [7:0] ab, input logic [7:0] bb, input logic [7:0] rb,
                          input logic f, input logic [127:0] exp_r, input int exp_lat,
                          input logic exp_c, input logic exp_z, input logic poke);
        int  n_eff, lat, wcnt, idx;
        bit  got;
        wr_t w;
        n_eff = (n > MAXLEN) ? MAXLEN : n;
        for (int i = 0; i < n_eff; i++) begin
            idx = (o == MP_SHR) ? (n_eff - 1 - i) : i;
            w.addr = rb + 8'(idx);
            w.data = exp_r[idx*8 +: 8];
            exp_q.push_back(w);
        end
        @(negedge clk);
        op = o; len = n[LW-1:0]; a_base = ab; b_base = bb; r_base = rb; fill_i = f; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; wcnt = 0; got = 0;
        for (int k = 0; k < 200; k++) begin
            if (poke && lat == 3) begin
                start = 1'b1; op = MP_SHR; len = '0; r_base = 8'hEE;
            end else begin
                start = 1'b0;
            end
            if (lat == 2) check({tag, "_busy"}, 32'(busy), 32'(n_eff != 0));
            if (mem_we) begin
                wcnt++;
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check({tag, "_waddr"}, 32'(mem_waddr), 32'(w.addr));
                    check({tag, "_wdata"}, 32'(mem_wdata), 32'(w.data));
                end
            end
            if (done) begin
                got = 1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(got), 32'(1));
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_writes"}, 32'(wcnt), 32'(n_eff));
        check({tag, "_busy_at_done"}, 32'(busy), 32'(0));
        check({tag, "_carry"}, 32'(carry_o), 32'(exp_c));
        check({tag, "_zero"}, 32'(zero_o), 32'(exp_z));
        exp_q.delete();
        if (poke) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_done_pulse"}, 32'(done), 32'(0));
        check({tag, "_idle"}, 32'(busy), 32'(0));
        if (poke) begin
            @(posedge clk); #1;
            check({tag, "_start_in_done_ignored"}, 32'(busy | done), 32'(0));
        end
        $display("op %s: type=%0d len=%0d latency=%0d writes=%0d carry=%0b zero=%0b",
                 tag, o, n, lat, wcnt, carry_o, zero_o);
    endtask

    initial begin
        int  wcnt;
        bit  seen_done;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_mem_we", 32'(mem_we), 32'(0));
        check("rst_mem_addr", 32'(mem_addr), 32'(0));
        check("rst_mem_wdata", 32'(mem_wdata), 32'(0));
        check("rst_alu_cmd", 32'(alu_cmd), 32'(ALU_ADD));
        check("rst_alu_sc_i", 32'(alu_sc_i), 32'(0));
        check("rst_carry", 32'(carry_o), 32'(0));
        check("rst_zero", 32'(zero_o), 32'(1));
        @(negedge clk);
        reset_n = 1'b1;

        // 1: ADD 0x01FF + 0x0001
        load(8'h10, 2, 128'h01FF);
        load(8'h20, 2, 128'h0001);
        run_op("add2", MP_ADD, 2, 8'h10, 8'h20, 8'h30, 1'b0, 128'h0200, 7, 1'b0, 1'b0, 1'b0);

        // 2: SUB with borrow, then without
        load(8'h40, 2, 128'h0000);
        load(8'h50, 2, 128'h0001);
        run_op("sub_borrow", MP_SUB, 2, 8'h40, 8'h50, 8'h60, 1'b0, 128'hFFFF, 7, 1'b0, 1'b0, 1'b0);
        load(8'h44, 2, 128'h0005);
        load(8'h54, 2, 128'h0003);
        run_op("sub_ok", MP_SUB, 2, 8'h44, 8'h54, 8'h64, 1'b0, 128'h0002, 7, 1'b1, 1'b0, 1'b0);

        // 3: shifts
        load(8'h70, 2, 128'h8001);
        run_op("shl2", MP_SHL, 2, 8'h70, 8'h00, 8'h74, 1'b0, 128'h0002, 5, 1'b1, 1'b0, 1'b0);
        load(8'h78, 2, 128'h0100);
        run_op("shr2", MP_SHR, 2, 8'h78, 8'h00, 8'h7C, 1'b1, 128'h8080, 5, 1'b0, 1'b0, 1'b0);

        // 4: single byte with carry out and zero result; zero-length ops
        load(8'h80, 1, 128'hFF);
        load(8'h81, 1, 128'h01);
        run_op("add1", MP_ADD, 1, 8'h80, 8'h81, 8'h82, 1'b0, 128'h00, 4, 1'b1, 1'b1, 1'b0);
        run_op("add_len0", MP_ADD, 0, 8'h80, 8'h81, 8'h82, 1'b0, 128'h0, 1, 1'b0, 1'b1, 1'b0);
        run_op("sub_len0", MP_SUB, 0, 8'h80, 8'h81, 8'h82, 1'b0, 128'h0, 1, 1'b1, 1'b1, 1'b0);

        // 5: in-place with address wrap, start poked while busy and in DONE
        load(8'hFF, 2, 128'h12FF);
        load(8'h90, 2, 128'h0001);
        run_op("add_inplace_wrap", MP_ADD, 2, 8'hFF, 8'h90, 8'hFF, 1'b0, 128'h1300, 7, 1'b0, 1'b0, 1'b1);
        check("inplace_mem_ff", 32'(mem[8'hFF]), 32'h00);
        check("inplace_mem_00", 32'(mem[8'h00]), 32'h13);

        // Oversized length clamps to MAXLEN
        load(8'hA0, 16, 128'h0);
        run_op("shl_clamp", MP_SHL, 31, 8'hA0, 8'h00, 8'hB0, 1'b0, 128'h0, 2*MAXLEN+1, 1'b0, 1'b1, 1'b0);

        // 6: reset during the second EXEC of a 4-byte ADD
        load(8'hC0, 4, 128'h04030201);
        load(8'hC8, 4, 128'h40302010);
        @(negedge clk);
        op = MP_ADD; len = LW'(4); a_base = 8'hC0; b_base = 8'hC8; r_base = 8'hD0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wcnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (mem_we) wcnt++;
            if (wcnt == 2) break;
            @(posedge clk); #1;
        end
        check("rst_mid_reached_exec2", 32'(wcnt), 32'(2));
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'(0));
        check("rst_mid_mem_we", 32'(mem_we), 32'(0));
        seen_done = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            seen_done = seen_done | done;
        end
        check("rst_mid_no_done", 32'(seen_done), 32'(0));
        check("rst_mid_byte0_kept", 32'(mem[8'hD0]), 32'h11);
        @(negedge clk);
        reset_n = 1'b1;
        run_op("add4_after_rst", MP_ADD, 4, 8'hC0, 8'hC8, 8'hD0, 1'b0, 128'h44332211, 13, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
